// File: rtl/btn_pkg.sv
// btn_debounce shared types: channel FSM states and counter sizing.
// Long-press support is enabled with BTN_DEBOUNCE_LONG_PRESS_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    SETTLE_DN = 2'd1,
    DOWN      = 2'd2,
    SETTLE_UP = 2'd3
  } btn_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, settle FSM and counter.
// BTN_DEBOUNCE_LONG_PRESS_EN adds a saturating hold counter for btn_long.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 16777216
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("btn_debounce_ch: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic rel_q, rel_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= UP;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds the number of consecutive cycles s2 has matched the
  // candidate level; acceptance happens on the cycle it would reach the limit.
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UP: begin
        if (s2_q) begin
          state_d = SETTLE_DN;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE_DN: begin
        if (!s2_q) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DOWN: begin
        if (!s2_q) begin
          state_d = SETTLE_UP;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE_UP: begin
        if (s2_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == DOWN) || (state_d == SETTLE_UP);
    press_d = (state_q == SETTLE_DN) && (state_d == DOWN);
    rel_d   = (state_q == SETTLE_UP) && (state_d == UP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic [HW-1:0] hold_q, hold_d;
  logic long_q, long_d;

  always_comb begin
    hold_d = hold_q;
    if (press_d || rel_d) begin
      hold_d = '0;
    end else if (((state_q == DOWN) || (state_q == SETTLE_UP))
                 && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
    end
    long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign lng = long_q;
`else
  assign lng = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTN independent debounced channels.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to enable the btn_long pulse.
module btn_debounce #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 16777216
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .lng  (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Expected output vectors are queued per driven cycle and popped after the edge.
module tb_btn_debounce;

  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int LAT = DEB + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
    logic [1:0] lng;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  btn_debounce #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    exp_t o;
    o.lvl = btn_level;
    o.prs = btn_press;
    o.rls = btn_release;
    o.lng = btn_long;
    return o;
  endfunction

  task automatic test_reset();
    exp_t e, o;
    rst_n = 1'b0;
    btn_raw = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst_n = 1'b1;
      if (i >= 3) btn_raw = 2'b00;
      e = '0;
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b want=%b", i, o, e);
      end
    end
  endtask

  task automatic test_clean_press();
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      btn_raw = 2'b01;
      e = '0;
      e.lvl[0] = (i >= LAT);
      e.prs[0] = (i == LAT);
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL press cyc=%0d got=%b want=%b", i, o, e);
      end
    end
  endtask

  task automatic test_release();
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      btn_raw = 2'b00;
      e = '0;
      e.lvl[0] = (i < LAT);
      e.rls[0] = (i == LAT);
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL release cyc=%0d got=%b want=%b", i, o, e);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e, o;
    for (int i = 0; i < 14; i++) begin
      btn_raw = {1'b0, (i != 3)};
      e = '0;
      e.lvl[0] = (i >= 4 + LAT);
      e.prs[0] = (i == 4 + LAT);
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", i, o, e);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e, o;
    for (int i = 0; i < 12; i++) begin
      btn_raw = {(i < DEB - 1), 1'b0};
      e = '0;
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    for (int i = 0; i < 14; i++) begin
      btn_raw = 2'b01;
      rst_n = !((i == 3) || (i == 4));
      e = '0;
      e.lvl[0] = (i >= 5 + LAT);
      e.prs[0] = (i == 5 + LAT);
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%b want=%b", i, o, e);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_long_press();
    exp_t e, o;
    for (int i = 0; i < LAT + 31; i++) begin
      btn_raw = 2'b01;
      e = '0;
      e.lvl[0] = (i >= LAT);
      e.prs[0] = (i == LAT);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      e.lng[0] = (i == LAT + LNG);
`endif
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL long cyc=%0d got=%b want=%b", i, o, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_raw = '0;
    @(posedge clk); #1;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_glitch();
    test_reset_mid();
    test_release();
    test_long_press();
    test_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
